// File: rtl/expansion_pipe_if.sv
// Valid/ready bus for expansion_pipe: input beat (half-block, subkey, key enable)
// and the expanded output beat. Bit k of every vector is DES bit k.
interface expansion_pipe_if #(
    parameter int unsigned DATA_W = 32
) ();
    localparam int unsigned OUT_W = 3 * DATA_W / 2;

    logic             in_valid;
    logic             in_ready;
    logic [DATA_W:1]  in_data;
    logic [OUT_W:1]   in_key;
    logic             in_key_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W:1]   out_data;

    modport master (
        output in_valid, in_data, in_key, in_key_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, in_key_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/expansion_pipe.sv
// Parametrised DES-style E-box: cyclic 4->6 expansion of a DATA_W half-block,
// optional subkey XOR, then PIPE_STAGES valid/ready register stages.
module expansion_pipe #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    expansion_pipe_if.slave bus,
    output logic            busy
);
    localparam int unsigned OUT_W  = 3 * DATA_W / 2;
    localparam int unsigned GROUPS = DATA_W / 4;
    localparam int          LAST   = int'(PIPE_STAGES) - 1;

    logic [OUT_W:1]         expand;
    logic [OUT_W:1]         mixed;
    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] valid_d;
    logic [PIPE_STAGES-1:0] take;
    logic [PIPE_STAGES-1:0] load;
    logic [PIPE_STAGES-1:0] adv;
    logic [OUT_W:1]         data_q [PIPE_STAGES];

    // Each 6-bit group takes its 4 own bits plus one neighbour on each side;
    // the first and last groups wrap around the half-block.
    always_comb begin
        expand = '0;
        for (int g = 0; g < int'(GROUPS); g++) begin
            expand[6*g+1] = bus.in_data[(g == 0) ? int'(DATA_W) : 4*g];
            for (int j = 0; j < 4; j++) begin
                expand[6*g+2+j] = bus.in_data[4*g+1+j];
            end
            expand[6*g+6] = bus.in_data[(g == int'(GROUPS) - 1) ? 1 : 4*g+5];
        end
    end

    assign mixed = bus.in_key_en ? (expand ^ bus.in_key) : expand;

    // take[i]: stage i can accept a beat this cycle (empty, or draining onward).
    always_comb begin
        take    = '0;
        load    = '0;
        adv     = '0;
        valid_d = valid_q;
        take[LAST] = !valid_q[LAST] || bus.out_ready;
        adv[LAST]  = valid_q[LAST] && bus.out_ready;
        for (int i = LAST - 1; i >= 0; i--) begin
            take[i] = !valid_q[i] || take[i+1];
            adv[i]  = valid_q[i] && take[i+1];
        end
        load[0] = bus.in_valid && take[0];
        for (int i = 1; i <= LAST; i++) begin
            load[i] = valid_q[i-1] && take[i];
        end
        for (int i = 0; i <= LAST; i++) begin
            valid_d[i] = load[i] || (valid_q[i] && !adv[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i <= LAST; i++) begin
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int i = 0; i <= LAST; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            if (load[0]) begin
                data_q[0] <= mixed;
            end
            for (int i = 1; i <= LAST; i++) begin
                if (load[i]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    // flush discards the same-cycle beat, so upstream is never held off by it.
    assign bus.in_ready  = flush || take[0];
    assign bus.out_valid = valid_q[LAST];
    assign bus.out_data  = data_q[LAST];
    assign busy          = |valid_q;
endmodule

// File: tb/tb_expansion_pipe.sv
// Bench for expansion_pipe: a DES-sized 2-stage instance and a 64-bit 1-stage
// instance, each checked against an independent expansion model via scoreboard.
module tb_expansion_pipe;
    localparam int WA = 32;
    localparam int LA = 2;
    localparam int OA = 48;
    localparam int WB = 64;
    localparam int LB = 1;
    localparam int OB = 96;

    localparam logic [31:0] DesIn   = 32'b11110000101010101111000010101010;
    localparam logic [47:0] DesKey  = 48'b000110110000001011101111111111000111000001110010;
    localparam logic [47:0] DesOutK = 48'b011000010001011110111010100001100110010100100111;
    localparam logic [47:0] DesOutE = 48'b011110100001010101010101011110100001010101010101;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    logic busy_a;
    logic busy_b;

    int n_tests = 0;
    int n_fail = 0;
    int out_cnt_a = 0;
    int out_cnt_b = 0;

    always #5 clk = ~clk;

    expansion_pipe_if #(.DATA_W(WA)) ifa ();
    expansion_pipe_if #(.DATA_W(WB)) ifb ();

    expansion_pipe #(.DATA_W(WA), .PIPE_STAGES(LA)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_a),
        .bus   (ifa),
        .busy  (busy_a)
    );

    expansion_pipe #(.DATA_W(WB), .PIPE_STAGES(LB)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush_b),
        .bus   (ifb),
        .busy  (busy_b)
    );

    // Output bit j draws from input bit 4*group + position, wrapped into 1..W.
    function automatic logic [OA:1] model_a(input logic [WA:1] d, input logic [OA:1] k,
                                            input logic en);
        logic [OA:1] e;
        int src;
        for (int j = 1; j <= OA; j++) begin
            src = 4 * ((j - 1) / 6) + (j - 1) % 6;
            if (src == 0) src = WA;
            else if (src == WA + 1) src = 1;
            e[j] = d[src];
        end
        return en ? (e ^ k) : e;
    endfunction

    function automatic logic [OB:1] model_b(input logic [WB:1] d, input logic [OB:1] k,
                                            input logic en);
        logic [OB:1] e;
        int src;
        for (int j = 1; j <= OB; j++) begin
            src = 4 * ((j - 1) / 6) + (j - 1) % 6;
            if (src == 0) src = WB;
            else if (src == WB + 1) src = 1;
            e[j] = d[src];
        end
        return en ? (e ^ k) : e;
    endfunction

    // Vectors are written bit 1 leftmost; place bit k at index k.
    function automatic logic [32:1] pk32(input logic [31:0] s);
        logic [32:1] r;
        for (int k = 1; k <= 32; k++) r[k] = s[32-k];
        return r;
    endfunction

    function automatic logic [48:1] pk48(input logic [47:0] s);
        logic [48:1] r;
        for (int k = 1; k <= 48; k++) r[k] = s[48-k];
        return r;
    endfunction

    logic [OA:1] q_a [$];
    logic [OB:1] q_b [$];
    logic [OA:1] exp_a, pd_a;
    logic [OB:1] exp_b, pd_b;
    logic pv_a = 1'b0, pr_a = 1'b0, pf_a = 1'b1;
    logic pv_b = 1'b0, pr_b = 1'b0, pf_b = 1'b1;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q_a.delete();
            pf_a = 1'b1;
        end else begin
            if (!pf_a && pv_a && !pr_a) begin
                n_tests++;
                if (ifa.out_valid !== 1'b1 || ifa.out_data !== pd_a) begin
                    n_fail++;
                    $display("FAIL stall_hold_a: got v=%b %h want v=1 %h",
                             ifa.out_valid, ifa.out_data, pd_a);
                end
            end
            if (!pf_a && !pv_a && ifa.out_valid === 1'b0) begin
                n_tests++;
                if (ifa.out_data !== pd_a) begin
                    n_fail++;
                    $display("FAIL idle_hold_a: got %h want %h", ifa.out_data, pd_a);
                end
            end
            if (flush_a) begin
                q_a.delete();
            end else begin
                if (ifa.out_valid && ifa.out_ready) begin
                    n_tests++;
                    out_cnt_a++;
                    if (q_a.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out_a: got %h want nothing", ifa.out_data);
                    end else begin
                        exp_a = q_a.pop_front();
                        if (ifa.out_data !== exp_a) begin
                            n_fail++;
                            $display("FAIL data_a: got %h want %h", ifa.out_data, exp_a);
                        end
                    end
                end
                if (ifa.in_valid && ifa.in_ready)
                    q_a.push_back(model_a(ifa.in_data, ifa.in_key, ifa.in_key_en));
            end
            pf_a = flush_a;
        end
        pv_a = ifa.out_valid;
        pr_a = ifa.out_ready;
        pd_a = ifa.out_data;
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q_b.delete();
            pf_b = 1'b1;
        end else begin
            if (!pf_b && pv_b && !pr_b) begin
                n_tests++;
                if (ifb.out_valid !== 1'b1 || ifb.out_data !== pd_b) begin
                    n_fail++;
                    $display("FAIL stall_hold_b: got v=%b %h want v=1 %h",
                             ifb.out_valid, ifb.out_data, pd_b);
                end
            end
            if (!pf_b && !pv_b && ifb.out_valid === 1'b0) begin
                n_tests++;
                if (ifb.out_data !== pd_b) begin
                    n_fail++;
                    $display("FAIL idle_hold_b: got %h want %h", ifb.out_data, pd_b);
                end
            end
            if (flush_b) begin
                q_b.delete();
            end else begin
                if (ifb.out_valid && ifb.out_ready) begin
                    n_tests++;
                    out_cnt_b++;
                    if (q_b.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_out_b: got %h want nothing", ifb.out_data);
                    end else begin
                        exp_b = q_b.pop_front();
                        if (ifb.out_data !== exp_b) begin
                            n_fail++;
                            $display("FAIL data_b: got %h want %h", ifb.out_data, exp_b);
                        end
                    end
                end
                if (ifb.in_valid && ifb.in_ready)
                    q_b.push_back(model_b(ifb.in_data, ifb.in_key, ifb.in_key_en));
            end
            pf_b = flush_b;
        end
        pv_b = ifb.out_valid;
        pr_b = ifb.out_ready;
        pd_b = ifb.out_data;
    end

    task automatic test_reset();
        #2;
        n_tests++;
        if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0 || ifa.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b busy=%b d=%h want 0 0 0",
                     ifa.out_valid, busy_a, ifa.out_data);
        end
        n_tests++;
        if (ifb.out_valid !== 1'b0 || busy_b !== 1'b0 || ifb.out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b busy=%b d=%h want 0 0 0",
                     ifb.out_valid, busy_b, ifb.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b %b want 1 1", ifa.in_ready, ifb.in_ready);
        end
    endtask

    task automatic test_des(input logic en, input logic [47:0] want, input string name);
        int lat;
        @(posedge clk); #1;
        ifa.in_data   = pk32(DesIn);
        ifa.in_key    = pk48(DesKey);
        ifa.in_key_en = en;
        ifa.in_valid  = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        lat = 1;
        while (ifa.out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != LA) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d", name, lat, LA);
        end
        n_tests++;
        if (ifa.out_data !== pk48(want)) begin
            n_fail++;
            $display("FAIL %s_value: got %h want %h", name, ifa.out_data, pk48(want));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_walk_a();
        logic [WA:1] oh;
        int lat;
        for (int b = 1; b <= WA; b++) begin
            oh = '0;
            oh[b] = 1'b1;
            ifa.in_data   = oh;
            ifa.in_key    = '0;
            ifa.in_key_en = 1'b0;
            ifa.in_valid  = 1'b1;
            @(posedge clk); #1;
            ifa.in_valid = 1'b0;
            lat = 1;
            while (ifa.out_valid !== 1'b1 && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            n_tests++;
            if (lat != LA || ifa.out_data !== model_a(oh, '0, 1'b0)) begin
                n_fail++;
                $display("FAIL walk_a bit %0d: got lat=%0d %h want lat=%0d %h",
                         b, lat, ifa.out_data, LA, model_a(oh, '0, 1'b0));
            end
            if (b == WA) begin
                n_tests++;
                if (ifa.out_data[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_low_a: got out[1]=%b want 1", ifa.out_data[1]);
                end
            end
            if (b == 1) begin
                n_tests++;
                if (ifa.out_data[OA] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL wrap_high_a: got out[48]=%b want 1", ifa.out_data[OA]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int c = 0;
        int base;
        int inflight;
        bit saw_stall = 0;
        logic [63:0] r;
        base = out_cnt_a;
        while ((sent < 6 || out_cnt_a - base < 6) && c < 40) begin
            @(posedge clk); #1;
            c++;
            ifa.out_ready = !(c >= 3 && c <= 7);
            if (sent < 6) begin
                r = {$urandom(), $urandom()};
                ifa.in_data   = r[31:0];
                ifa.in_key    = r[47:0];
                ifa.in_key_en = r[63];
                ifa.in_valid  = 1'b1;
            end else begin
                ifa.in_valid = 1'b0;
            end
            #1;
            if (ifa.in_ready !== 1'b1) begin
                saw_stall = 1;
                inflight = sent - (out_cnt_a - base);
                n_tests++;
                if (inflight != LA) begin
                    n_fail++;
                    $display("FAIL bp_ready_drop: got %0d held want %0d", inflight, LA);
                end
            end
            if (ifa.in_valid && ifa.in_ready) sent++;
        end
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        n_tests++;
        if (!saw_stall) begin
            n_fail++;
            $display("FAIL bp_stall_seen: got in_ready never low want low while full");
        end
        n_tests++;
        if (out_cnt_a - base != 6 || q_a.size() != 0) begin
            n_fail++;
            $display("FAIL bp_count: got %0d out %0d queued want 6 out 0 queued",
                     out_cnt_a - base, q_a.size());
        end
    endtask

    task automatic test_flush();
        int base;
        base = out_cnt_a;
        @(posedge clk); #1;
        ifa.out_ready = 1'b0;
        ifa.in_data   = 32'h1234_5678;
        ifa.in_key_en = 1'b0;
        ifa.in_valid  = 1'b1;
        @(posedge clk); #1;
        ifa.in_data = 32'h9abc_def0;
        @(posedge clk); #1;
        ifa.in_data = 32'h0f0f_0f0f;
        flush_a = 1'b1;
        #1;
        n_tests++;
        if (ifa.in_ready !== 1'b1 || busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_in_ready: got rdy=%b busy=%b want 1 1", ifa.in_ready, busy_a);
        end
        @(posedge clk); #1;
        flush_a       = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        n_tests++;
        if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0 || ifa.out_data !== '0) begin
            n_fail++;
            $display("FAIL flush_clear: got v=%b busy=%b d=%h want 0 0 0",
                     ifa.out_valid, busy_a, ifa.out_data);
        end
        repeat (5) @(posedge clk);
        #1;
        n_tests++;
        if (out_cnt_a != base) begin
            n_fail++;
            $display("FAIL flush_no_emit: got %0d beats want 0", out_cnt_a - base);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(posedge clk); #1;
        ifa.in_data   = 32'hdead_beef;
        ifa.in_key_en = 1'b0;
        ifa.in_valid  = 1'b1;
        @(posedge clk); #1;
        ifa.in_data = 32'hcafe_f00d;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0 || ifa.out_data !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b busy=%b d=%h want 0 0 0",
                     ifa.out_valid, busy_a, ifa.out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ifa.out_valid !== 1'b0 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got v=%b busy=%b want 0 0", ifa.out_valid, busy_a);
        end
        ifa.in_data  = 32'h0123_4567;
        ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        lat = 1;
        while (ifa.out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != LA) begin
            n_fail++;
            $display("FAIL post_reset_latency: got %0d want %0d", lat, LA);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_w64();
        logic [WB:1] oh;
        logic [WB:1] prev;
        int lat;
        int base;
        ifb.in_data   = 64'h0123_4567_89ab_cdef;
        ifb.in_key_en = 1'b0;
        ifb.in_key    = '0;
        ifb.in_valid  = 1'b1;
        @(posedge clk); #1;
        ifb.in_valid = 1'b0;
        lat = 1;
        while (ifb.out_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != LB) begin
            n_fail++;
            $display("FAIL w64_latency: got %0d want %0d", lat, LB);
        end
        @(posedge clk); #1;
        base = out_cnt_b;
        prev = '0;
        for (int b = 1; b <= WB; b++) begin
            oh = '0;
            oh[b] = 1'b1;
            ifb.in_data  = oh;
            ifb.in_valid = 1'b1;
            #1;
            n_tests++;
            if (ifb.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL w64_in_ready bit %0d: got %b want 1", b, ifb.in_ready);
            end
            if (b > 1) begin
                n_tests++;
                if (ifb.out_valid !== 1'b1 || ifb.out_data !== model_b(prev, '0, 1'b0)) begin
                    n_fail++;
                    $display("FAIL w64_stream bit %0d: got v=%b %h want v=1 %h", b - 1,
                             ifb.out_valid, ifb.out_data, model_b(prev, '0, 1'b0));
                end
            end
            prev = oh;
            @(posedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_cnt_b - base != WB) begin
            n_fail++;
            $display("FAIL w64_throughput: got %0d beats want %0d", out_cnt_b - base, WB);
        end
    endtask

    task automatic test_back_to_back();
        int sa = 0;
        int sb = 0;
        int c = 0;
        int ba;
        int bb;
        bit acc_a = 0;
        bit acc_b = 0;
        logic [95:0] r;
        ba = out_cnt_a;
        bb = out_cnt_b;
        while ((out_cnt_a - ba < 24 || out_cnt_b - bb < 24) && c < 400) begin
            @(posedge clk); #1;
            c++;
            if (acc_a) ifa.in_valid = 1'b0;
            if (acc_b) ifb.in_valid = 1'b0;
            if (!ifa.in_valid && sa < 24) begin
                r = {$urandom(), $urandom(), $urandom()};
                ifa.in_data   = r[31:0];
                ifa.in_key    = r[79:32];
                ifa.in_key_en = r[95];
                ifa.in_valid  = 1'b1;
            end
            if (!ifb.in_valid && sb < 24) begin
                r = {$urandom(), $urandom(), $urandom()};
                ifb.in_data   = r[63:0];
                ifb.in_key    = r;
                ifb.in_key_en = r[94];
                ifb.in_valid  = 1'b1;
            end
            ifa.out_ready = ($urandom_range(3) != 0);
            ifb.out_ready = ($urandom_range(3) != 0);
            #1;
            acc_a = ifa.in_valid && ifa.in_ready;
            acc_b = ifb.in_valid && ifb.in_ready;
            if (acc_a) sa++;
            if (acc_b) sb++;
        end
        ifa.in_valid  = 1'b0;
        ifb.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        n_tests++;
        if (out_cnt_a - ba != 24 || out_cnt_b - bb != 24 || q_a.size() != 0 || q_b.size() != 0)
        begin
            n_fail++;
            $display("FAIL b2b_count: got a=%0d b=%0d want 24 24 (cycles %0d)",
                     out_cnt_a - ba, out_cnt_b - bb, c);
        end
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_key = '0; ifa.in_key_en = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.in_key = '0; ifb.in_key_en = 1'b0;
        ifb.out_ready = 1'b1;
        test_reset();
        test_des(1'b1, DesOutK, "des_key");
        test_des(1'b0, DesOutE, "des_e");
        test_walk_a();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_w64();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
